// File: rtl/gpr_bank.sv
// Integer register file with N combinational read ports, two write-back ports
// (ALU and load) and a per-register busy scoreboard. Register 0 reads as zero, never busy.
module gpr_bank #(
    parameter int unsigned WordSize = 32,
    parameter int unsigned NumRegs  = 32,
    parameter int unsigned NumRead  = 2,
    parameter int unsigned Bypass   = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NumRead*$clog2(NumRegs)-1:0] rd_addr,
    output logic [NumRead*WordSize-1:0]   rd_data,
    output logic [NumRead-1:0]            rd_busy,
    input  logic                          wb0_en,
    input  logic [$clog2(NumRegs)-1:0]    wb0_addr,
    input  logic [WordSize-1:0]           wb0_data,
    input  logic                          wb1_en,
    input  logic [$clog2(NumRegs)-1:0]    wb1_addr,
    input  logic [WordSize-1:0]           wb1_data,
    input  logic                          rsv_en,
    input  logic [$clog2(NumRegs)-1:0]    rsv_addr,
    output logic                          busy_any
);

    localparam int unsigned AddrW = $clog2(NumRegs);

    logic [WordSize-1:0] regs_q [NumRegs];
    logic [NumRegs-1:0]  busy_q;
    logic [NumRegs-1:0]  busy_d;

    // Scoreboard next state: a new reservation outranks a completing write-back.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NumRegs; r++) begin
            if (rsv_en && (rsv_addr == AddrW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wb0_en && (wb0_addr == AddrW'(r))) ||
                         (wb1_en && (wb1_addr == AddrW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Storage; the later wb1 assignment lets the load win a same-address collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (wb0_en && (wb0_addr != '0)) begin
                regs_q[wb0_addr] <= wb0_data;
            end
            if (wb1_en && (wb1_addr != '0)) begin
                regs_q[wb1_addr] <= wb1_data;
            end
        end
    end

    // Read ports; forwarding is suppressed during reset so outputs read as zero.
    for (genvar k = 0; k < NumRead; k++) begin : g_rd
        logic [AddrW-1:0] addr;
        logic             hit0;
        logic             hit1;

        assign addr = rd_addr[k*AddrW +: AddrW];
        assign hit1 = (Bypass != 0) && rstn && wb1_en && (wb1_addr == addr) && (addr != '0);
        assign hit0 = (Bypass != 0) && rstn && wb0_en && (wb0_addr == addr) && (addr != '0);

        assign rd_data[k*WordSize +: WordSize] = (addr == '0) ? '0 :
                                                 hit1         ? wb1_data :
                                                 hit0         ? wb0_data :
                                                                regs_q[addr];
        assign rd_busy[k] = (addr == '0)    ? 1'b0 :
                            (hit1 || hit0)  ? (rsv_en && (rsv_addr == addr)) :
                                              busy_q[addr];
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_gpr_bank.sv
// Directed and random checks of gpr_bank against a register/scoreboard model:
// two 32x32 2-port banks (bypass on / off) share stimulus, plus a 64x64 4-port bank.
module tb_gpr_bank;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 32x32 banks
    logic [2*AW-1:0] ab_rd_addr;
    logic [63:0]     a_rd_data, b_rd_data;
    logic [1:0]      a_rd_busy, b_rd_busy;
    logic            ab_wb0_en, ab_wb1_en, ab_rsv_en;
    logic [AW-1:0]   ab_wb0_addr, ab_wb1_addr, ab_rsv_addr;
    logic [31:0]     ab_wb0_data, ab_wb1_data;
    logic            a_busy_any, b_busy_any;

    // 64 regs x 64 bits, 4 read ports
    logic [4*CW-1:0] c_rd_addr;
    logic [255:0]    c_rd_data;
    logic [3:0]      c_rd_busy;
    logic            c_wb0_en, c_wb1_en, c_rsv_en;
    logic [CW-1:0]   c_wb0_addr, c_wb1_addr, c_rsv_addr;
    logic [63:0]     c_wb0_data, c_wb1_data;
    logic            c_busy_any;

    gpr_bank #(.WordSize(32), .NumRegs(32), .NumRead(2), .Bypass(1)) dut_a (
        .clk(clk), .rstn(rstn), .rd_addr(ab_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wb0_en(ab_wb0_en), .wb0_addr(ab_wb0_addr),
        .wb0_data(ab_wb0_data), .wb1_en(ab_wb1_en), .wb1_addr(ab_wb1_addr),
        .wb1_data(ab_wb1_data), .rsv_en(ab_rsv_en), .rsv_addr(ab_rsv_addr),
        .busy_any(a_busy_any)
    );

    gpr_bank #(.WordSize(32), .NumRegs(32), .NumRead(2), .Bypass(0)) dut_b (
        .clk(clk), .rstn(rstn), .rd_addr(ab_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wb0_en(ab_wb0_en), .wb0_addr(ab_wb0_addr),
        .wb0_data(ab_wb0_data), .wb1_en(ab_wb1_en), .wb1_addr(ab_wb1_addr),
        .wb1_data(ab_wb1_data), .rsv_en(ab_rsv_en), .rsv_addr(ab_rsv_addr),
        .busy_any(b_busy_any)
    );

    gpr_bank #(.WordSize(64), .NumRegs(64), .NumRead(4), .Bypass(1)) dut_c (
        .clk(clk), .rstn(rstn), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wb0_en(c_wb0_en), .wb0_addr(c_wb0_addr),
        .wb0_data(c_wb0_data), .wb1_en(c_wb1_en), .wb1_addr(c_wb1_addr),
        .wb1_data(c_wb1_data), .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr),
        .busy_any(c_busy_any)
    );

    // Model state: index 0 = the 32x32 banks, index 1 = the 64x64 bank
    logic [63:0] m_regs [2][64];
    bit          m_busy [2][64];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 64; r++) begin
                m_regs[m][r] = '0;
                m_busy[m][r] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input int m, input bit w0e, input int w0a, input logic [63:0] w0d,
                              input bit w1e, input int w1a, input logic [63:0] w1d,
                              input bit re, input int ra);
        if (w0e && w0a != 0) begin m_regs[m][w0a] = w0d; m_busy[m][w0a] = 1'b0; end
        if (w1e && w1a != 0) begin m_regs[m][w1a] = w1d; m_busy[m][w1a] = 1'b0; end
        if (re && ra != 0) m_busy[m][ra] = 1'b1;
    endtask

    // Expected {busy, data} for a read of address a in model m
    function automatic logic [64:0] exp_rd(input int m, input int a, input bit byp);
        bit w0e, w1e, re;
        int w0a, w1a, ra;
        logic [63:0] w0d, w1d;
        if (m == 0) begin
            w0e = ab_wb0_en; w0a = int'(ab_wb0_addr); w0d = 64'(ab_wb0_data);
            w1e = ab_wb1_en; w1a = int'(ab_wb1_addr); w1d = 64'(ab_wb1_data);
            re  = ab_rsv_en; ra  = int'(ab_rsv_addr);
        end else begin
            w0e = c_wb0_en; w0a = int'(c_wb0_addr); w0d = c_wb0_data;
            w1e = c_wb1_en; w1a = int'(c_wb1_addr); w1d = c_wb1_data;
            re  = c_rsv_en; ra  = int'(c_rsv_addr);
        end
        if (!rstn || a == 0) return 65'd0;
        if (byp && w1e && w1a == a) return {(re && ra == a), w1d};
        if (byp && w0e && w0a == a) return {(re && ra == a), w0d};
        return {m_busy[m][a], m_regs[m][a]};
    endfunction

    function automatic bit any_busy(input int m);
        bit b = 1'b0;
        for (int r = 0; r < 64; r++) b |= m_busy[m][r];
        return b;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check(input string tag);
        logic [64:0] e;
        int a;
        for (int k = 0; k < 2; k++) begin
            a = int'(ab_rd_addr[k*AW +: AW]);
            e = exp_rd(0, a, 1'b1);
            cmp($sformatf("%s a_data[%0d] x%0d", tag, k, a), 64'(a_rd_data[k*32 +: 32]), 64'(e[31:0]));
            cmp($sformatf("%s a_busy[%0d] x%0d", tag, k, a), 64'(a_rd_busy[k]), 64'(e[64]));
            e = exp_rd(0, a, 1'b0);
            cmp($sformatf("%s b_data[%0d] x%0d", tag, k, a), 64'(b_rd_data[k*32 +: 32]), 64'(e[31:0]));
            cmp($sformatf("%s b_busy[%0d] x%0d", tag, k, a), 64'(b_rd_busy[k]), 64'(e[64]));
        end
        cmp($sformatf("%s a_busy_any", tag), 64'(a_busy_any), 64'(any_busy(0)));
        cmp($sformatf("%s b_busy_any", tag), 64'(b_busy_any), 64'(any_busy(0)));
        for (int k = 0; k < 4; k++) begin
            a = int'(c_rd_addr[k*CW +: CW]);
            e = exp_rd(1, a, 1'b1);
            cmp($sformatf("%s c_data[%0d] x%0d", tag, k, a), c_rd_data[k*64 +: 64], e[63:0]);
            cmp($sformatf("%s c_busy[%0d] x%0d", tag, k, a), 64'(c_rd_busy[k]), 64'(e[64]));
        end
        cmp($sformatf("%s c_busy_any", tag), 64'(c_busy_any), 64'(any_busy(1)));
    endtask

    // Check the settled same-cycle view, then clock the DUTs and the model together
    task automatic tick(input string tag);
        #1;
        check(tag);
        @(posedge clk);
        if (rstn) begin
            model_edge(0, ab_wb0_en, int'(ab_wb0_addr), 64'(ab_wb0_data),
                       ab_wb1_en, int'(ab_wb1_addr), 64'(ab_wb1_data),
                       ab_rsv_en, int'(ab_rsv_addr));
            model_edge(1, c_wb0_en, int'(c_wb0_addr), c_wb0_data,
                       c_wb1_en, int'(c_wb1_addr), c_wb1_data,
                       c_rsv_en, int'(c_rsv_addr));
        end
        #1;
    endtask

    task automatic idle();
        ab_wb0_en = 1'b0; ab_wb0_addr = '0; ab_wb0_data = '0;
        ab_wb1_en = 1'b0; ab_wb1_addr = '0; ab_wb1_data = '0;
        ab_rsv_en = 1'b0; ab_rsv_addr = '0;
        c_wb0_en  = 1'b0; c_wb0_addr  = '0; c_wb0_data  = '0;
        c_wb1_en  = 1'b0; c_wb1_addr  = '0; c_wb1_data  = '0;
        c_rsv_en  = 1'b0; c_rsv_addr  = '0;
    endtask

    task automatic rd_ab(input int a0, input int a1);
        ab_rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        int base;
        idle();
        rd_ab(5, 6);
        c_rd_addr = {CW'(3), CW'(2), CW'(1), CW'(0)};
        model_reset();

        // Reset state
        #2;
        check("reset");
        tick("reset_edge");
        rstn = 1'b1;

        // Reset asserted mid-run discards state and same-cycle activity
        ab_wb0_en = 1'b1; ab_wb0_addr = AW'(5); ab_wb0_data = 32'hDEADBEEF;
        ab_rsv_en = 1'b1; ab_rsv_addr = AW'(6);
        tick("t1_wr");
        idle();
        tick("t1_held");
        ab_wb0_en = 1'b1; ab_wb0_addr = AW'(5); ab_wb0_data = 32'h12345678;
        ab_rsv_en = 1'b1; ab_rsv_addr = AW'(6);
        rstn = 1'b0;
        model_reset();
        tick("t1_in_rst");
        idle();
        rstn = 1'b1;
        tick("t1_release");
        tick("t1_after");

        // x0 protection
        rd_ab(0, 0);
        ab_wb0_en = 1'b1; ab_wb0_addr = '0; ab_wb0_data = 32'hFFFFFFFF;
        ab_wb1_en = 1'b1; ab_wb1_addr = '0; ab_wb1_data = 32'hFFFFFFFF;
        ab_rsv_en = 1'b1; ab_rsv_addr = '0;
        c_wb0_en  = 1'b1; c_wb0_addr  = '0; c_wb0_data  = '1;
        c_rsv_en  = 1'b1; c_rsv_addr  = '0;
        tick("t2_same");
        idle();
        tick("t2_next");

        // Write collision: load wins
        rd_ab(7, 7);
        ab_wb0_en = 1'b1; ab_wb0_addr = AW'(7); ab_wb0_data = 32'h11;
        ab_wb1_en = 1'b1; ab_wb1_addr = AW'(7); ab_wb1_data = 32'h22;
        tick("t3_same");
        idle();
        tick("t3_next");

        // Scoreboard
        rd_ab(3, 3);
        ab_rsv_en = 1'b1; ab_rsv_addr = AW'(3);
        tick("t4_rsv");
        idle();
        tick("t4_busy");
        ab_wb0_en = 1'b1; ab_wb0_addr = AW'(3); ab_wb0_data = 32'h33;
        ab_rsv_en = 1'b1; ab_rsv_addr = AW'(3);
        tick("t4_wr_rsv");
        idle();
        tick("t4_still");
        ab_wb1_en = 1'b1; ab_wb1_addr = AW'(3); ab_wb1_data = 32'h44;
        tick("t4_wb1");
        idle();
        tick("t4_clear");

        // Forwarding versus stored view
        rd_ab(9, 0);
        ab_rsv_en = 1'b1; ab_rsv_addr = AW'(9);
        tick("t5_rsv");
        idle();
        tick("t5_busy");
        ab_wb0_en = 1'b1; ab_wb0_addr = AW'(9); ab_wb0_data = 32'hABCD;
        tick("t5_byp");
        idle();
        tick("t5_after");

        // Fill the wide bank, two registers per cycle
        for (int r = 0; r < 64; r += 2) begin
            c_wb0_en = 1'b1; c_wb0_addr = CW'(r);     c_wb0_data = 64'(r)     * 64'h0101010101010101;
            c_wb1_en = 1'b1; c_wb1_addr = CW'(r + 1); c_wb1_data = 64'(r + 1) * 64'h0101010101010101;
            tick("c_fill");
        end
        idle();
        for (int i = 0; i < 24; i++) begin
            base = int'($urandom_range(0, 63));
            c_rd_addr = {CW'(base + 51), CW'(base + 34), CW'(base + 17), CW'(base)};
            c_rsv_en  = ($urandom_range(0, 2) == 0);
            c_rsv_addr = CW'($urandom_range(0, 63));
            c_wb0_en  = ($urandom_range(0, 1) == 0);
            c_wb0_addr = CW'($urandom_range(0, 63));
            c_wb0_data = {$urandom, $urandom};
            tick("c_read");
        end
        idle();

        // Random traffic on all banks; small address windows provoke collisions
        for (int i = 0; i < 400; i++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 3 : 31;
            rd_ab(int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
            ab_wb0_en = 1'($urandom); ab_wb0_addr = AW'($urandom_range(0, lim)); ab_wb0_data = $urandom;
            ab_wb1_en = 1'($urandom); ab_wb1_addr = AW'($urandom_range(0, lim)); ab_wb1_data = $urandom;
            ab_rsv_en = 1'($urandom); ab_rsv_addr = AW'($urandom_range(0, lim));
            c_rd_addr = {CW'($urandom_range(0, lim)), CW'($urandom_range(0, lim)),
                         CW'($urandom_range(0, 63)), CW'($urandom_range(0, lim))};
            c_wb0_en = 1'($urandom); c_wb0_addr = CW'($urandom_range(0, lim)); c_wb0_data = {$urandom, $urandom};
            c_wb1_en = 1'($urandom); c_wb1_addr = CW'($urandom_range(0, lim)); c_wb1_data = {$urandom, $urandom};
            c_rsv_en = 1'($urandom); c_rsv_addr = CW'($urandom_range(0, lim));
            tick("rand");
        end
        idle();
        tick("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
